// File: rtl/isa_slave_window_ctrl.sv
// ISA slave front end: windowed I/O decode, strobe synchronisers and a req/ack handshake to the fabric.
// Optional memory-cycle support is enabled by defining ISA_MEM_WINDOWS_EN.
module isa_slave_window_ctrl #(
  parameter int NUM_WIN       = 4,
  parameter int WIN_SIZE_LOG2 = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int ADS_SETTLE    = 2,
  parameter int MAX_WAIT      = 15
) (
  input  logic                       FPGACLK,
  input  logic                       RESET,
  input  logic [19:0]                addressBus,
  input  logic                       BALE,
  input  logic                       SBHE,
  input  logic                       IOR,
  input  logic                       IOW,
  input  logic                       MEMR,
  input  logic                       MEMW,
  input  logic [NUM_WIN*20-1:0]      win_base,
  input  logic [NUM_WIN-1:0]         win_en,
  input  logic                       ack,
  output logic                       IOCS16,
  output logic                       MEMCS16,
  output logic                       NOWS,
  output logic                       IO_RDY,
  output logic                       ADS_OE,
  output logic                       ADS_LATCH,
  output logic [3:0]                 TE,
  output logic                       FPGA_WR,
  output logic                       req,
  output logic                       req_wr,
  output logic                       req_mem,
  output logic                       req_wide,
  output logic [2:0]                 req_win,
  output logic [WIN_SIZE_LOG2-1:0]   req_off,
  output logic                       timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DECODE, S_STROBE, S_WAIT, S_DRIVE, S_RELEASE
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(ADS_SETTLE - 1);
  localparam logic [7:0] WAIT_LAST   = 8'(MAX_WAIT - 1);

  // Synchroniser bit order: {MEMW, MEMR,} SBHE, IOW, IOR, BALE
`ifdef ISA_MEM_WINDOWS_EN
  localparam int NSYNC = 6;
  logic [NSYNC-1:0] sync_in;
  assign sync_in = {MEMW, MEMR, SBHE, IOW, IOR, BALE};
`else
  localparam int NSYNC = 4;
  logic [NSYNC-1:0] sync_in;
  assign sync_in = {SBHE, IOW, IOR, BALE};
`endif

  localparam logic [NSYNC-1:0] SYNC_RST = {{(NSYNC-1){1'b1}}, 1'b0};

  logic [NSYNC-1:0] sync_q [SYNC_STAGES];
  logic [NSYNC-1:0] sync_s;
  logic bale_s, ior_s, iow_s, sbhe_s, memr_s, memw_s;

  always_ff @(posedge FPGACLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= sync_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign bale_s = sync_s[0];
  assign ior_s  = sync_s[1];
  assign iow_s  = sync_s[2];
  assign sbhe_s = sync_s[3];
`ifdef ISA_MEM_WINDOWS_EN
  assign memr_s = sync_s[4];
  assign memw_s = sync_s[5];
`else
  assign memr_s = 1'b1;
  assign memw_s = 1'b1;
`endif

  // Window decode runs on the live address so IOCS16 is valid from DECODE onward
  logic       dec_hit;
  logic [2:0] dec_win;
  always_comb begin
    dec_hit = 1'b0;
    dec_win = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      if (!dec_hit && win_en[i] &&
          addressBus[19:WIN_SIZE_LOG2] == win_base[20*i+WIN_SIZE_LOG2 +: 20-WIN_SIZE_LOG2]) begin
        dec_hit = 1'b1;
        dec_win = 3'(i);
      end
    end
  end

  state_e                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [WIN_SIZE_LOG2-1:0] off_q, off_d;
  logic [2:0]               win_q, win_d;
  logic                     hit_q, hit_d;
  logic                     sbhe_q, sbhe_d;
  logic                     bale_prev_q;
  logic                     iocs16_q, iocs16_d;
  logic                     memcs16_q, memcs16_d;
  logic                     io_rdy_q, io_rdy_d;
  logic                     ads_oe_q, ads_oe_d;
  logic [3:0]               te_q, te_d;
  logic                     fpga_wr_q, fpga_wr_d;
  logic                     req_q, req_d;
  logic                     req_wr_q, req_wr_d;
  logic                     req_mem_q, req_mem_d;
  logic                     req_wide_q, req_wide_d;
  logic [2:0]               req_win_q, req_win_d;
  logic [WIN_SIZE_LOG2-1:0] req_off_q, req_off_d;
  logic                     timeout_q, timeout_d;

  logic       st_ior, st_iow, st_memr, st_memw;
  logic [2:0] n_low;
  logic       bale_rise, active_hi;
  logic [3:0] te_sel;

  assign st_ior    = ~ior_s;
  assign st_iow    = ~iow_s;
  assign st_memr   = ~memr_s;
  assign st_memw   = ~memw_s;
  assign n_low     = {2'b0, st_ior} + {2'b0, st_iow} + {2'b0, st_memr} + {2'b0, st_memw};
  assign bale_rise = bale_s & ~bale_prev_q;
  assign active_hi = req_mem_q ? (req_wr_q ? memw_s : memr_s)
                               : (req_wr_q ? iow_s  : ior_s);

  always_comb begin
    unique case ({req_wide_q, req_off_q[0]})
      2'b10:   te_sel = 4'b1100;
      2'b11:   te_sel = 4'b0011;
      2'b00:   te_sel = 4'b1110;
      default: te_sel = 4'b0111;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    win_d      = win_q;
    hit_d      = hit_q;
    sbhe_d     = sbhe_q;
    iocs16_d   = iocs16_q;
    memcs16_d  = memcs16_q;
    io_rdy_d   = io_rdy_q;
    ads_oe_d   = ads_oe_q;
    te_d       = te_q;
    fpga_wr_d  = fpga_wr_q;
    req_d      = req_q;
    req_wr_d   = req_wr_q;
    req_mem_d  = req_mem_q;
    req_wide_d = req_wide_q;
    req_win_d  = req_win_q;
    req_off_d  = req_off_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (bale_s) begin
          state_d  = S_ADDR;
          cnt_d    = '0;
          ads_oe_d = 1'b0;
        end
      end
      S_ADDR: begin
        if (cnt_q >= SETTLE_LAST) begin
          ads_oe_d = 1'b1;
          off_d    = addressBus[WIN_SIZE_LOG2-1:0];
          sbhe_d   = sbhe_s;
          hit_d    = dec_hit;
          win_d    = dec_win;
          if (dec_hit && !sbhe_s) begin
            iocs16_d  = 1'b0;
            memcs16_d = 1'b0;
          end
          state_d  = S_DECODE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DECODE: state_d = hit_q ? S_STROBE : S_IDLE;
      S_STROBE: begin
        // Strobes are ignored while BALE is high so refresh cycles pass unseen
        if (!bale_s) begin
          if (n_low > 3'd1) begin
            iocs16_d  = 1'b1;
            memcs16_d = 1'b1;
            state_d   = S_IDLE;
          end else if (n_low == 3'd1) begin
            io_rdy_d   = 1'b0;
            req_d      = 1'b1;
            req_wr_d   = st_iow | st_memw;
            req_mem_d  = st_memr | st_memw;
            req_wide_d = ~sbhe_q;
            req_win_d  = win_q;
            req_off_d  = off_q;
            cnt_d      = '0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (ack || cnt_q >= WAIT_LAST) begin
          if (!ack) timeout_d = 1'b1;
          req_d     = 1'b0;
          io_rdy_d  = 1'b1;
          fpga_wr_d = ~req_wr_q;
          te_d      = te_sel;
          state_d   = S_DRIVE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRIVE: begin
        if (active_hi) begin
          te_d      = '1;
          fpga_wr_d = 1'b0;
          iocs16_d  = 1'b1;
          memcs16_d = 1'b1;
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (bale_rise && state_q != S_IDLE && state_q != S_ADDR) begin
      te_d      = '1;
      fpga_wr_d = 1'b0;
      io_rdy_d  = 1'b1;
      iocs16_d  = 1'b1;
      memcs16_d = 1'b1;
      req_d     = 1'b0;
      ads_oe_d  = 1'b0;
      cnt_d     = '0;
      state_d   = S_ADDR;
    end
  end

  always_ff @(posedge FPGACLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      win_q       <= '0;
      hit_q       <= 1'b0;
      sbhe_q      <= 1'b1;
      bale_prev_q <= 1'b0;
      iocs16_q    <= 1'b1;
      memcs16_q   <= 1'b1;
      io_rdy_q    <= 1'b1;
      ads_oe_q    <= 1'b1;
      te_q        <= '1;
      fpga_wr_q   <= 1'b0;
      req_q       <= 1'b0;
      req_wr_q    <= 1'b0;
      req_mem_q   <= 1'b0;
      req_wide_q  <= 1'b0;
      req_win_q   <= '0;
      req_off_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      win_q       <= win_d;
      hit_q       <= hit_d;
      sbhe_q      <= sbhe_d;
      bale_prev_q <= bale_s;
      iocs16_q    <= iocs16_d;
      memcs16_q   <= memcs16_d;
      io_rdy_q    <= io_rdy_d;
      ads_oe_q    <= ads_oe_d;
      te_q        <= te_d;
      fpga_wr_q   <= fpga_wr_d;
      req_q       <= req_d;
      req_wr_q    <= req_wr_d;
      req_mem_q   <= req_mem_d;
      req_wide_q  <= req_wide_d;
      req_win_q   <= req_win_d;
      req_off_q   <= req_off_d;
      timeout_q   <= timeout_d;
    end
  end

  logic unused_base;
  assign unused_base = ^win_base;

`ifdef ISA_MEM_WINDOWS_EN
  assign MEMCS16 = memcs16_q;
`else
  logic unused_mem;
  assign unused_mem = MEMR ^ MEMW ^ memcs16_q;
  assign MEMCS16    = 1'b1;
`endif

  assign IOCS16    = iocs16_q;
  assign NOWS      = 1'b1;
  assign IO_RDY    = io_rdy_q;
  assign ADS_OE    = ads_oe_q;
  assign ADS_LATCH = BALE;
  assign TE        = te_q;
  assign FPGA_WR   = fpga_wr_q;
  assign req       = req_q;
  assign req_wr    = req_wr_q;
  assign req_mem   = req_mem_q;
  assign req_wide  = req_wide_q;
  assign req_win   = req_win_q;
  assign req_off   = req_off_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_isa_slave_window_ctrl.sv
// Directed bench for isa_slave_window_ctrl with hand-computed expectations.
module tb_isa_slave_window_ctrl;

  logic        FPGACLK = 1'b0;
  logic        RESET;
  logic [19:0] addressBus;
  logic        BALE, SBHE, IOR, IOW, MEMR, MEMW;
  logic [79:0] win_base;
  logic [3:0]  win_en;
  logic        ack;
  logic        IOCS16, MEMCS16, NOWS, IO_RDY, ADS_OE, ADS_LATCH;
  logic [3:0]  TE;
  logic        FPGA_WR, req, req_wr, req_mem, req_wide;
  logic [2:0]  req_win;
  logic [3:0]  req_off;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  isa_slave_window_ctrl #(
    .NUM_WIN(4), .WIN_SIZE_LOG2(4), .SYNC_STAGES(2), .ADS_SETTLE(2), .MAX_WAIT(15)
  ) dut (
    .FPGACLK(FPGACLK), .RESET(RESET), .addressBus(addressBus), .BALE(BALE),
    .SBHE(SBHE), .IOR(IOR), .IOW(IOW), .MEMR(MEMR), .MEMW(MEMW),
    .win_base(win_base), .win_en(win_en), .ack(ack),
    .IOCS16(IOCS16), .MEMCS16(MEMCS16), .NOWS(NOWS), .IO_RDY(IO_RDY),
    .ADS_OE(ADS_OE), .ADS_LATCH(ADS_LATCH), .TE(TE), .FPGA_WR(FPGA_WR),
    .req(req), .req_wr(req_wr), .req_mem(req_mem), .req_wide(req_wide),
    .req_win(req_win), .req_off(req_off), .timeout(timeout)
  );

  always #5 FPGACLK = ~FPGACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_strobe(input logic wr, input logic lvl);
    if (wr) IOW = lvl;
    else    IOR = lvl;
  endtask

  // Address phase: BALE pulse, settle window, decode; returns with the FSM in STROBE or IDLE
  task automatic isa_addr(input logic [19:0] a, input logic sbhe, input logic exp_cs);
    @(negedge FPGACLK);
    addressBus = a;
    SBHE       = sbhe;
    BALE       = 1'b1;
    repeat (2) @(negedge FPGACLK);
    BALE = 1'b0;
    @(negedge FPGACLK);
    check("ads_oe_low", 32'(ADS_OE), 32'd0);
    repeat (2) @(negedge FPGACLK);
    check("ads_oe_high", 32'(ADS_OE), 32'd1);
    check("iocs16_decode", 32'(IOCS16), 32'(exp_cs));
    @(negedge FPGACLK);
  endtask

  task automatic strobe_go(input logic wr);
    int cyc;
    set_strobe(wr, 1'b0);
    cyc = 0;
    while (cyc < 10) begin
      @(negedge FPGACLK);
      cyc++;
      if (req) break;
    end
    check("req_latency", 32'(cyc), 32'd3);
  endtask

  task automatic strobe_end(input logic wr);
    int cyc;
    set_strobe(wr, 1'b1);
    cyc = 0;
    while (cyc < 10) begin
      @(negedge FPGACLK);
      cyc++;
      if (TE == 4'hF) break;
    end
    check("te_release_latency", 32'(cyc), 32'd3);
    check("fpga_wr_release", 32'(FPGA_WR), 32'd0);
    check("iocs16_release", 32'(IOCS16), 32'd1);
    @(negedge FPGACLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt, highcnt;
    logic seen;
    RESET = 1'b1; BALE = 1'b0; SBHE = 1'b1; IOR = 1'b1; IOW = 1'b1;
    MEMR = 1'b1; MEMW = 1'b1; ack = 1'b0; addressBus = '0;
    win_en = '0; win_base = '0;
    repeat (3) @(negedge FPGACLK);
    check("rst_iocs16", 32'(IOCS16), 32'd1);
    check("rst_memcs16", 32'(MEMCS16), 32'd1);
    check("rst_nows", 32'(NOWS), 32'd1);
    check("rst_io_rdy", 32'(IO_RDY), 32'd1);
    check("rst_ads_oe", 32'(ADS_OE), 32'd1);
    check("rst_te", 32'(TE), 32'hF);
    check("rst_fpga_wr", 32'(FPGA_WR), 32'd0);
    check("rst_req", 32'(req), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    RESET = 1'b0;

    // 8-bit read hit on window 0, ack three cycles after req
    win_base = {20'h00000, 20'h00300, 20'h00000, 20'h00420};
    win_en   = 4'b0101;
    isa_addr(20'h00423, 1'b1, 1'b1);
    strobe_go(1'b0);
    check("rd_req_win", 32'(req_win), 32'd0);
    check("rd_req_off", 32'(req_off), 32'd3);
    check("rd_req_wr", 32'(req_wr), 32'd0);
    check("rd_req_wide", 32'(req_wide), 32'd0);
    check("rd_req_mem", 32'(req_mem), 32'd0);
    check("rd_io_rdy_low", 32'(IO_RDY), 32'd0);
    lowcnt = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge FPGACLK);
      if (IO_RDY == 1'b0) lowcnt++;
      if (i == 3) ack = 1'b1;
      if (i == 4) begin
        ack = 1'b0;
        check("rd_req_dropped", 32'(req), 32'd0);
        check("rd_te_drive", 32'(TE), 32'b0111);
        check("rd_fpga_wr", 32'(FPGA_WR), 32'd1);
        check("rd_req_off_hold", 32'(req_off), 32'd3);
      end
    end
    check("rd_io_rdy_low_cycles", 32'(lowcnt), 32'd4);
    check("rd_te_hold", 32'(TE), 32'b0111);
    strobe_end(1'b0);

    // 16-bit write hit on window 2
    isa_addr(20'h00302, 1'b0, 1'b0);
    strobe_go(1'b1);
    check("wr_req_win", 32'(req_win), 32'd2);
    check("wr_req_off", 32'(req_off), 32'd2);
    check("wr_req_wr", 32'(req_wr), 32'd1);
    check("wr_req_wide", 32'(req_wide), 32'd1);
    check("wr_iocs16", 32'(IOCS16), 32'd0);
    ack = 1'b1;
    @(negedge FPGACLK);
    ack = 1'b0;
    check("wr_req_dropped", 32'(req), 32'd0);
    check("wr_io_rdy", 32'(IO_RDY), 32'd1);
    check("wr_te", 32'(TE), 32'b1100);
    check("wr_fpga_wr", 32'(FPGA_WR), 32'd0);
    check("wr_iocs16_drive", 32'(IOCS16), 32'd0);
    strobe_end(1'b1);

    // Miss with no window enabled
    win_en = 4'b0000;
    isa_addr(20'h00500, 1'b0, 1'b1);
    IOR  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge FPGACLK);
      if (req) seen = 1'b1;
    end
    check("miss_no_req", 32'(seen), 32'd0);
    check("miss_io_rdy", 32'(IO_RDY), 32'd1);
    check("miss_te", 32'(TE), 32'hF);
    check("miss_iocs16", 32'(IOCS16), 32'd1);
    IOR = 1'b1;
    repeat (3) @(negedge FPGACLK);

    // Overlapping windows 1 and 3: lowest index wins
    win_base = {20'h00640, 20'h00000, 20'h00640, 20'h00000};
    win_en   = 4'b1010;
    isa_addr(20'h00645, 1'b1, 1'b1);
    strobe_go(1'b0);
    check("ovl_req_win", 32'(req_win), 32'd1);
    check("ovl_req_off", 32'(req_off), 32'd5);
    ack = 1'b1;
    @(negedge FPGACLK);
    ack = 1'b0;
    check("ovl_te", 32'(TE), 32'b0111);
    strobe_end(1'b0);

    // Handshake timeout, ack never asserted
    win_base = {60'h0, 20'h00420};
    win_en   = 4'b0001;
    isa_addr(20'h00423, 1'b1, 1'b1);
    strobe_go(1'b0);
    highcnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge FPGACLK);
      if (req) highcnt++;
    end
    check("to_req_cycles", 32'(highcnt), 32'd15);
    check("to_flag", 32'(timeout), 32'd1);
    check("to_io_rdy", 32'(IO_RDY), 32'd1);
    check("to_te", 32'(TE), 32'b0111);
    strobe_end(1'b0);
    check("to_sticky", 32'(timeout), 32'd1);

    // BALE rising during WAIT aborts back to ADDR
    isa_addr(20'h00423, 1'b1, 1'b1);
    strobe_go(1'b0);
    BALE = 1'b1;
    IOR  = 1'b1;
    repeat (3) @(negedge FPGACLK);
    check("abort_req", 32'(req), 32'd0);
    check("abort_te", 32'(TE), 32'hF);
    check("abort_io_rdy", 32'(IO_RDY), 32'd1);
    check("abort_in_addr", 32'(ADS_OE), 32'd0);
    BALE = 1'b0;
    repeat (5) @(negedge FPGACLK);
    strobe_go(1'b0);
    ack = 1'b1;
    @(negedge FPGACLK);
    ack = 1'b0;
    check("abort_recover_te", 32'(TE), 32'b0111);
    strobe_end(1'b0);

    // Asynchronous reset while driving the bus
    isa_addr(20'h00422, 1'b0, 1'b0);
    strobe_go(1'b0);
    check("rstd_req_wide", 32'(req_wide), 32'd1);
    ack = 1'b1;
    @(negedge FPGACLK);
    ack = 1'b0;
    check("rstd_te_drive", 32'(TE), 32'b1100);
    check("rstd_fpga_wr_drive", 32'(FPGA_WR), 32'd1);
    @(posedge FPGACLK);
    #2 RESET = 1'b1;
    #1;
    check("rstd_te", 32'(TE), 32'hF);
    check("rstd_fpga_wr", 32'(FPGA_WR), 32'd0);
    check("rstd_iocs16", 32'(IOCS16), 32'd1);
    check("rstd_io_rdy", 32'(IO_RDY), 32'd1);
    check("rstd_req", 32'(req), 32'd0);
    check("rstd_req_wide", 32'(req_wide), 32'd0);
    check("rstd_timeout", 32'(timeout), 32'd0);
    @(negedge FPGACLK);
    RESET = 1'b0;
    IOR   = 1'b1;
    repeat (4) @(negedge FPGACLK);
    check("rstd_te_after", 32'(TE), 32'hF);

    // Refresh: IOR pulsed while BALE is high produces no request
    @(negedge FPGACLK);
    addressBus = 20'h00424;
    SBHE       = 1'b1;
    BALE       = 1'b1;
    seen       = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge FPGACLK);
      if (i == 4)  IOR  = 1'b0;
      if (i == 7)  IOR  = 1'b1;
      if (i == 10) BALE = 1'b0;
      if (req || !IO_RDY) seen = 1'b1;
    end
    check("refresh_no_req", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
